// File: rtl/systolic_mm_stream_if.sv
// Operand/result stream bundle for systolic_mm_stream: operand beats in, the
// drained result matrix out, plus the per-element saturation flags and busy.
interface systolic_mm_stream_if #(
    parameter int N      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [N*DATA_W-1:0]     a_col;
    logic [N*DATA_W-1:0]     b_row;
    logic                    out_valid;
    logic                    out_ready;
    logic [N*N*ACC_W-1:0]    result;
    logic [N*N-1:0]          sat_flag;
    logic                    busy;

    modport master (
        output in_valid, in_last, a_col, b_row, out_ready,
        input  in_ready, out_valid, result, sat_flag, busy
    );

    modport slave (
        input  in_valid, in_last, a_col, b_row, out_ready,
        output in_ready, out_valid, result, sat_flag, busy
    );
endinterface

// File: rtl/systolic_mm_stream.sv
// N x N output-stationary systolic MAC array computing C = A x B over a
// streamed K dimension, with internal operand skew and a drain/handshake FSM.
module systolic_mm_stream #(
    parameter int N        = 3,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_mm_stream_if.slave  s
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int SW = ((ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W) + 1;
    localparam int CW = $clog2(2*N) + 1;
    // Drain ends on the edge that lands the last skewed product plus one, so
    // out_valid rises exactly 2N cycles after the final beat.
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2*N-1);
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    // Returns {overflow_flag, next_accumulator} for one multiply-accumulate.
    function automatic logic [ACC_W:0] mac_step(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] prod;
        logic signed [SW-1:0]       sum;
        logic [ACC_W:0]             res;
        prod = a * b;
        sum  = SW'(acc) + SW'(prod);
        if (SATURATE == 0) begin
            res = {1'b0, sum[ACC_W-1:0]};
        end else if (sum > SAT_MAX) begin
            res = {1'b1, SAT_MAX[ACC_W-1:0]};
        end else if (sum < SAT_MIN) begin
            res = {1'b1, SAT_MIN[ACC_W-1:0]};
        end else begin
            res = {1'b0, sum[ACC_W-1:0]};
        end
        return res;
    endfunction

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      accept_s, clear_s, mac_en_s, in_ready_s;
    logic signed [DATA_W-1:0]  a_in_s [N];
    logic signed [DATA_W-1:0]  b_in_s [N];
    logic signed [DATA_W-1:0]  a_sk_q [N][N-1];
    logic signed [DATA_W-1:0]  a_sk_d [N][N-1];
    logic signed [DATA_W-1:0]  b_sk_q [N][N-1];
    logic signed [DATA_W-1:0]  b_sk_d [N][N-1];
    logic signed [DATA_W-1:0]  a_pe_q [N][N];
    logic signed [DATA_W-1:0]  a_pe_d [N][N];
    logic signed [DATA_W-1:0]  b_pe_q [N][N];
    logic signed [DATA_W-1:0]  b_pe_d [N][N];
    logic signed [ACC_W-1:0]   acc_q  [N][N];
    logic signed [ACC_W-1:0]   acc_d  [N][N];
    logic                      sat_q  [N][N];
    logic                      sat_d  [N][N];
    logic [ACC_W:0]            step_s [N][N];
    logic [N*N*ACC_W-1:0]      result_s;
    logic [N*N-1:0]            sat_flag_s;

    assign in_ready_s = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept_s   = s.in_valid && in_ready_s;

    // Job sequencing: accept beats, run the drain counter, hold results until taken.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_s  = 1'b0;
        mac_en_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    clear_s = 1'b1;
                    cnt_d   = '0;
                    state_d = s.in_last ? S_DRAIN : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                mac_en_s = 1'b1;
                if (accept_s && s.in_last) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                mac_en_s = 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (s.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand skew, PE-to-PE forwarding and the accumulators themselves.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (accept_s) begin
                a_in_s[i] = s.a_col[(N-1-i)*DATA_W +: DATA_W];
                b_in_s[i] = s.b_row[(N-1-i)*DATA_W +: DATA_W];
            end else begin
                a_in_s[i] = '0;
                b_in_s[i] = '0;
            end
            a_sk_d[i][0] = a_in_s[i];
            b_sk_d[i][0] = b_in_s[i];
            for (int d = 1; d < N-1; d++) begin
                a_sk_d[i][d] = a_sk_q[i][d-1];
                b_sk_d[i][d] = b_sk_q[i][d-1];
            end
        end
        a_pe_d[0][0] = a_in_s[0];
        b_pe_d[0][0] = b_in_s[0];
        for (int i = 1; i < N; i++) begin
            a_pe_d[i][0] = a_sk_q[i][i-1];
            b_pe_d[0][i] = b_sk_q[i][i-1];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                a_pe_d[i][j] = a_pe_q[i][j-1];
                b_pe_d[j][i] = b_pe_q[j-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                step_s[i][j] = mac_step(acc_q[i][j], a_pe_q[i][j], b_pe_q[i][j]);
                if (clear_s) begin
                    acc_d[i][j] = '0;
                    sat_d[i][j] = 1'b0;
                end else if (mac_en_s) begin
                    acc_d[i][j] = step_s[i][j][ACC_W-1:0];
                    sat_d[i][j] = sat_q[i][j] | step_s[i][j][ACC_W];
                end else begin
                    acc_d[i][j] = acc_q[i][j];
                    sat_d[i][j] = sat_q[i][j];
                end
            end
        end
    end

    // Flatten the accumulator grid onto the result bus, element (0,0) in the MSBs.
    always_comb begin
        result_s   = '0;
        sat_flag_s = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                result_s[(N*N-1-(i*N+j))*ACC_W +: ACC_W] = acc_q[i][j];
                sat_flag_s[N*N-1-(i*N+j)]                = sat_q[i][j];
            end
        end
    end

    // State, skew, pipeline and accumulator registers; reset aborts any job.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N-1; d++) begin
                    a_sk_q[i][d] <= '0;
                    b_sk_q[i][d] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                    sat_q[i][j]  <= 1'b0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N-1; d++) begin
                    a_sk_q[i][d] <= a_sk_d[i][d];
                    b_sk_q[i][d] <= b_sk_d[i][d];
                end
                for (int j = 0; j < N; j++) begin
                    a_pe_q[i][j] <= a_pe_d[i][j];
                    b_pe_q[i][j] <= b_pe_d[i][j];
                    acc_q[i][j]  <= acc_d[i][j];
                    sat_q[i][j]  <= sat_d[i][j];
                end
            end
        end
    end

    assign s.in_ready  = in_ready_s;
    assign s.out_valid = (state_q == S_DONE);
    assign s.busy      = (state_q != S_IDLE);
    assign s.result    = result_s;
    assign s.sat_flag  = sat_flag_s;

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Randomized self-checking bench: three instances (wrap/40, saturate/16, wrap/16)
// share one operand stream and are compared against a plain-arithmetic model.
module tb_systolic_mm_stream;
    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int LAT  = 2*N;
    localparam int MAXK = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            out_ready = 1'b0;
    logic [N*DW-1:0] a_col = '0;
    logic [N*DW-1:0] b_row = '0;

    systolic_mm_stream_if #(.N(N), .DATA_W(DW), .ACC_W(40)) if0 ();
    systolic_mm_stream_if #(.N(N), .DATA_W(DW), .ACC_W(16)) if1 ();
    systolic_mm_stream_if #(.N(N), .DATA_W(DW), .ACC_W(16)) if2 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
    assign if0.in_last  = in_last;   assign if1.in_last  = in_last;   assign if2.in_last  = in_last;
    assign if0.a_col    = a_col;     assign if1.a_col    = a_col;     assign if2.a_col    = a_col;
    assign if0.b_row    = b_row;     assign if1.b_row    = b_row;     assign if2.b_row    = b_row;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

    systolic_mm_stream #(.N(N), .DATA_W(DW), .ACC_W(40), .SATURATE(0)) dut0 (.clk(clk), .reset(reset), .s(if0));
    systolic_mm_stream #(.N(N), .DATA_W(DW), .ACC_W(16), .SATURATE(1)) dut1 (.clk(clk), .reset(reset), .s(if1));
    systolic_mm_stream #(.N(N), .DATA_W(DW), .ACC_W(16), .SATURATE(0)) dut2 (.clk(clk), .reset(reset), .s(if2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DW-1:0] ja [MAXK][N];
    logic signed [DW-1:0] jb [MAXK][N];
    int                   gap [MAXK];
    logic [N*N*40-1:0]    exp0;
    logic [N*N*16-1:0]    exp1;
    logic [N*N*16-1:0]    exp2;
    logic [N*N-1:0]       exps1;
    logic                 started = 1'b0;
    logic                 last_seen = 1'b0;
    logic                 run_en = 1'b0;
    int                   last_cyc = 0;
    int                   n_chk = 0;
    int                   n_err = 0;

    task automatic chk(input string name, input logic [399:0] act, input logic [399:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [39:0] r0(input int i, input int j);
        return if0.result[(N*N-1-(i*N+j))*40 +: 40];
    endfunction
    function automatic logic [15:0] r1(input int i, input int j);
        return if1.result[(N*N-1-(i*N+j))*16 +: 16];
    endfunction
    function automatic logic [15:0] r2(input int i, input int j);
        return if2.result[(N*N-1-(i*N+j))*16 +: 16];
    endfunction

    // Reference: exact integer dot products, then wrap or step-by-step clamp.
    task automatic compute_expected(input int k_len);
        longint s, t, p;
        logic   f;
        int     idx;
        exp0 = '0; exp1 = '0; exp2 = '0; exps1 = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0; t = 0; f = 1'b0;
                for (int k = 0; k < k_len; k++) begin
                    p = longint'(ja[k][i]) * longint'(jb[k][j]);
                    s = s + p;
                    t = t + p;
                    if (t > 32767) begin t = 32767; f = 1'b1; end
                    else if (t < -32768) begin t = -32768; f = 1'b1; end
                end
                idx = N*N-1-(i*N+j);
                exp0[idx*40 +: 40] = s[39:0];
                exp1[idx*16 +: 16] = t[15:0];
                exp2[idx*16 +: 16] = s[15:0];
                exps1[idx]         = f;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        logic e_ov;
        if (run_en && !reset) begin
            e_ov = last_seen && ((cyc - last_cyc) >= LAT);
            chk("out_valid0", 400'(if0.out_valid), 400'(e_ov));
            chk("out_valid1", 400'(if1.out_valid), 400'(e_ov));
            chk("out_valid2", 400'(if2.out_valid), 400'(e_ov));
            chk("in_ready",   400'(if0.in_ready),  400'(!last_seen));
            chk("busy",       400'(if0.busy),      400'(started));
            if (e_ov) begin
                chk("result40w", 400'(if0.result),   400'(exp0));
                chk("result16s", 400'(if1.result),   400'(exp1));
                chk("result16w", 400'(if2.result),   400'(exp2));
                chk("sat16s",    400'(if1.sat_flag), 400'(exps1));
                chk("sat40w",    400'(if0.sat_flag), 400'(0));
                chk("sat16w",    400'(if2.sat_flag), 400'(0));
            end
        end
    end

    task automatic junk_cycle(input logic allow_valid);
        in_valid  = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        in_last   = 1'($urandom_range(0, 1));
        a_col     = (N*DW)'({$urandom, $urandom});
        b_row     = (N*DW)'({$urandom, $urandom});
        out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_beats(input int k_len);
        compute_expected(k_len);
        for (int k = 0; k < k_len; k++) begin
            for (int g = 0; g < gap[k]; g++) junk_cycle(1'b0);
            in_valid = 1'b1;
            in_last  = (k == k_len-1);
            for (int i = 0; i < N; i++) begin
                a_col[(N-1-i)*DW +: DW] = ja[k][i];
                b_row[(N-1-i)*DW +: DW] = jb[k][i];
            end
            @(posedge clk); #1;
            started = 1'b1;
            if (k == k_len-1) begin
                last_seen = 1'b1;
                last_cyc  = cyc;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        while (cyc < last_cyc + LAT) junk_cycle(1'b1);
    endtask

    task automatic release_job(input int hold);
        repeat (hold) junk_cycle(1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        started   = 1'b0;
        last_seen = 1'b0;
    endtask

    task automatic set_scen1();
        for (int k = 0; k < 3; k++) begin
            gap[k] = 0;
            for (int i = 0; i < N; i++) begin
                ja[k][i] = (i == k) ? 16'sd1 : 16'sd0;
                jb[k][i] = 16'(3*k + i + 1);
            end
        end
    endtask

    task automatic set_const(input int k_len, input logic signed [DW-1:0] av, input logic signed [DW-1:0] bv);
        for (int k = 0; k < k_len; k++) begin
            gap[k] = 0;
            for (int i = 0; i < N; i++) begin
                ja[k][i] = av;
                jb[k][i] = bv;
            end
        end
    endtask

    initial begin
        int kl;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_result",   400'(if0.result),    400'(0));
        chk("rst_out_valid", 400'(if0.out_valid), 400'(0));
        chk("rst_in_ready", 400'(if0.in_ready),  400'(1));
        chk("rst_busy",     400'(if0.busy),      400'(0));
        chk("rst_sat",      400'(if1.sat_flag),  400'(0));
        run_en = 1'b1;
        @(posedge clk); #1;

        // Identity x B gives B.
        set_scen1(); run_beats(3); wait_done();
        chk("s1_c00", 400'(r0(0, 0)), 400'(1));
        chk("s1_c01", 400'(r0(0, 1)), 400'(2));
        chk("s1_c10", 400'(r0(1, 0)), 400'(4));
        chk("s1_c22", 400'(r0(2, 2)), 400'(9));
        chk("s1_sat", 400'(if1.sat_flag), 400'(0));
        release_job(0);

        set_const(9, 16'sd1, 16'sd1); run_beats(9); wait_done();
        chk("s2_c12", 400'(r0(1, 2)), 400'(9));
        chk("s2_c20", 400'(r2(2, 0)), 400'(9));
        release_job(0);

        set_scen1(); gap[1] = 2; run_beats(3); wait_done();
        chk("s3_c21", 400'(r0(2, 1)), 400'(8));
        release_job(1);

        set_const(1, -16'sd3, 16'sd5); run_beats(1); wait_done();
        chk("s4_c00", 400'(r0(0, 0)), 400'(40'hFFFFFFFFF1));
        chk("s4_c22", 400'(r0(2, 2)), 400'(40'hFFFFFFFFF1));
        chk("s4_c11w16", 400'(r2(1, 1)), 400'(16'hFFF1));
        release_job(0);

        set_const(2, 16'sh7FFF, 16'sh7FFF); run_beats(2); wait_done();
        chk("s5_sat_c00",  400'(r1(0, 0)), 400'(16'h7FFF));
        chk("s5_sat_flag", 400'(if1.sat_flag), 400'(9'h1FF));
        chk("s5_wrap_c00", 400'(r2(0, 0)), 400'(16'h0002));
        chk("s5_wrap_flag", 400'(if2.sat_flag), 400'(0));
        chk("s5_w40_c00",  400'(r0(0, 0)), 400'(40'h007FFE0002));
        release_job(0);

        // Held DONE, then a job aborted by reset mid-drain, then a clean rerun.
        set_scen1(); run_beats(3); wait_done();
        release_job(5);
        set_scen1(); run_beats(3);
        junk_cycle(1'b1); junk_cycle(1'b1);
        reset = 1'b1; in_valid = 1'b0; started = 1'b0; last_seen = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("s6_abort_ov",    400'(if0.out_valid), 400'(0));
        chk("s6_abort_ready", 400'(if0.in_ready),  400'(1));
        chk("s6_abort_res",   400'(if0.result),    400'(0));
        set_scen1(); run_beats(3); wait_done();
        chk("s6_rerun_c22", 400'(r0(2, 2)), 400'(9));
        release_job(0);

        for (int job = 0; job < 20; job++) begin
            kl = $urandom_range(1, 8);
            for (int k = 0; k < kl; k++) begin
                gap[k] = $urandom_range(0, 3);
                for (int i = 0; i < N; i++) begin
                    ja[k][i] = (job < 10) ? 16'($urandom) : 16'($signed($urandom_range(0, 200)) - 100);
                    jb[k][i] = (job < 10) ? 16'($urandom) : 16'($signed($urandom_range(0, 200)) - 100);
                end
            end
            run_beats(kl);
            wait_done();
            release_job($urandom_range(0, 4));
        end

        run_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
